// File: rtl/edge_event_arbiter_pkg.sv
// Shared types, reset constants and width helper for the edge event arbiter.
package edge_event_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam state_t STATE_RST = IDLE;
  localparam int     PTR_RST   = 0;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/edge_event_arbiter_if.sv
// Event-arbiter port bundle; master is the arbiter side, slave is the driver/consumer side.
interface edge_event_arbiter_if
  import edge_event_arbiter_pkg::*;
#(
  parameter int N = 4
);
  localparam int IDW = clog2(N);

  logic [N-1:0]   entrada;
  logic [N-1:0]   enable;
  logic [N-1:0]   ovf_clr;
  logic           out_ready;
  logic           out_valid;
  logic [IDW-1:0] out_id;
  logic [N-1:0]   pending;
  logic [N-1:0]   overflow;

  modport master (
    input  entrada, enable, ovf_clr, out_ready,
    output out_valid, out_id, pending, overflow
  );

  modport slave (
    output entrada, enable, ovf_clr, out_ready,
    input  out_valid, out_id, pending, overflow
  );

endinterface

// File: rtl/edge_event_arbiter_edge_detect.sv
// Per-bit rising-edge detector; rise is combinational against the registered previous level.
// prev clears on reset, so a level held high through reset release reads as one edge.
module edge_detect_n #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] din,
  output logic [N-1:0] rise
);

  logic [N-1:0] prev;

  always_ff @(posedge clk) begin
    if (rst) prev <= '0;
    else     prev <= din;
  end

  assign rise = din & ~prev;

endmodule

// File: rtl/edge_event_arbiter.sv
// Latches enabled rising edges as sticky pending events and serves them round-robin over valid/ready.
// Rise to out_valid is 2 cycles; out_valid/out_id hold until handshake, one IDLE cycle between grants.
module edge_event_arbiter
  import edge_event_arbiter_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                clk,
  input  logic                rst,
  edge_event_arbiter_if.master ev
);

  localparam int IDW = clog2(N);

  state_t         state_q, state_d;
  logic [N-1:0]   rise, edg, clr_mask;
  logic [N-1:0]   pending_q, overflow_q;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] out_id_q, out_id_d;
  logic           out_valid_q, out_valid_d;
  logic           hs;

  edge_detect_n #(.N(N)) u_edge (
    .clk  (clk),
    .rst  (rst),
    .din  (ev.entrada),
    .rise (rise)
  );

  function automatic logic [IDW-1:0] rr_pick(input logic [N-1:0] req, input logic [IDW-1:0] ptr);
    logic [IDW-1:0] pick;
    logic           found;
    int             idx;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        pick  = IDW'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign edg = rise & ev.enable;
  assign hs  = out_valid_q & ev.out_ready;

  always_comb begin
    clr_mask = '0;
    for (int i = 0; i < N; i++) begin
      clr_mask[i] = hs && (int'(out_id_q) == i);
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    out_id_d    = out_id_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        out_valid_d = 1'b0;
        if (|pending_q) begin
          out_id_d    = rr_pick(pending_q, rr_ptr_q);
          out_valid_d = 1'b1;
          state_d     = GRANT;
        end
      end
      GRANT: begin
        out_valid_d = 1'b1;
        if (hs) begin
          rr_ptr_d    = (int'(out_id_q) == N - 1) ? '0 : out_id_q + 1'b1;
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A handshake clear and a same-cycle edge on that channel combine into "still pending", no overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= STATE_RST;
      rr_ptr_q    <= IDW'(PTR_RST);
      out_id_q    <= '0;
      out_valid_q <= 1'b0;
      pending_q   <= '0;
      overflow_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      out_id_q    <= out_id_d;
      out_valid_q <= out_valid_d;
      pending_q   <= (pending_q & ~clr_mask) | edg;
      overflow_q  <= (overflow_q & ~ev.ovf_clr) | (edg & pending_q & ~clr_mask);
    end
  end

  assign ev.out_valid = out_valid_q;
  assign ev.out_id    = out_id_q;
  assign ev.pending   = pending_q;
  assign ev.overflow  = overflow_q;

endmodule
